afu_rd_lat_mon: RTL
===================

AFU_RD_LAT_MON -- requirements
Module: afu_rd_lat_mon

Interface
REQ-001 SHALL have parameter ID_BITS, default 8, meaning the number of tracked ID bits; the monitor tracks 2^ID_BITS table entries.
REQ-002 SHALL have parameter TS_W, default 16, meaning the width of the timestamp and latency fields.
REQ-003 SHALL have port afu_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port afu_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_fire, input, 1 bit: a read address is accepted by the MC this cycle (arvalid && arready on the MC side of one channel).
REQ-006 SHALL have port req_id, input, ID_BITS bits: arid[ID_BITS-1:0] of the accepted read.
REQ-007 SHALL have port rsp_fire, input, 1 bit: read data is returned by the MC this cycle (rvalid; rready is always 1).
REQ-008 SHALL have port rsp_id, input, ID_BITS bits: rid[ID_BITS-1:0].
REQ-009 SHALL have port stat_clr, input, 1 bit: clears statistics and error flags; the ID table is not cleared.
REQ-010 SHALL have port lat_min, output, TS_W bits: minimum observed latency in cycles.
REQ-011 SHALL have port lat_max, output, TS_W bits: maximum observed latency in cycles.
REQ-012 SHALL have port lat_sum, output, 48 bits: sum of observed latencies, saturating.
REQ-013 SHALL have port rsp_cnt, output, 32 bits: number of matched responses, saturating.
REQ-014 SHALL have port outstanding, output, ID_BITS+1 bits: number of table entries currently valid.
REQ-015 SHALL have port err_dup, output, 1 bit: sticky flag, set when a request arrives whose ID is already outstanding.
REQ-016 SHALL have port err_orphan, output, 1 bit: sticky flag, set when a response arrives whose ID is not outstanding.

Function
REQ-017 SHALL run a free-running TS_W-bit cycle counter `now` that wraps modulo 2^TS_W.
REQ-018 SHALL, on req_fire, write ts[req_id] <= now and vld[req_id] <= 1.
REQ-019 SHALL, on rsp_fire with vld[rsp_id]=1, compute lat = (now - ts[rsp_id]) mod 2^TS_W and clear vld[rsp_id]; latencies of 2^TS_W cycles or more alias, by design.
REQ-020 SHALL define latency in edges: a request sampled at edge t0 and its response sampled at edge t1 give lat = t1 - t0; the minimum is 1.
REQ-021 SHALL, for a matched response, update at the next edge: lat_min <= min(lat_min, lat), lat_max <= max(lat_max, lat), lat_sum <= lat_sum + lat saturating at all-ones, rsp_cnt <= rsp_cnt + 1 saturating at all-ones. Statistics outputs are registered, with 1-cycle latency after the response edge.
REQ-022 SHALL, on rsp_fire with vld[rsp_id]=0, set err_orphan and leave the statistics and table unchanged.
REQ-023 SHALL, on req_fire with vld[req_id]=1 and no matching same-cycle response, set err_dup and overwrite ts; outstanding is unchanged.
REQ-024 SHALL, when req_fire and rsp_fire occur in the same cycle with the same ID, retire the old entry using the old ts, then rearm it with now; vld stays 1, outstanding is unchanged, and no error is raised.
REQ-025 SHALL handle outstanding as follows: +1 for a new (non-duplicate) request, -1 for a matched response, net 0 when both occur; it never exceeds 2^ID_BITS.
REQ-026 SHALL, on stat_clr, set lat_min to all-ones and lat_max, lat_sum, rsp_cnt, err_dup and err_orphan to 0. A response matched in the same cycle as stat_clr is discarded from the statistics but still clears its vld bit.
REQ-027 SHALL hold the statistics when there is no activity; outputs change only on matched responses, flag events, stat_clr or reset.

Reset
REQ-028 SHALL, on afu_rst, set now=0, every vld=0, outstanding=0, lat_min all-ones, lat_max=0, lat_sum=0, rsp_cnt=0, err_dup=0 and err_orphan=0; the ts contents need not be reset.
REQ-029 SHALL give afu_rst priority over every other input, and SHALL ignore req_fire/rsp_fire in the reset cycle; responses to requests issued before reset then count as orphans.

Verification
REQ-030 SHALL cover: request id 5 at cycle 10, response id 5 at cycle 42 -> lat_min=lat_max=32, lat_sum=32, rsp_cnt=1 one cycle later, outstanding back to 0.
REQ-031 SHALL cover: requests ids 1,2,3 on consecutive cycles, responses in order 3,1,2 with latencies 20,25,30 -> lat_min=20, lat_max=30, lat_sum=75, rsp_cnt=3, outstanding 3 then 0.
REQ-032 SHALL cover: response id 9 with nothing outstanding -> err_orphan=1 and rsp_cnt=0; then stat_clr -> err_orphan=0 and lat_min=16'hFFFF.
REQ-033 SHALL cover: request id 7 twice, 5 cycles apart -> err_dup=1, outstanding=1, and a later response measures from the second request.
REQ-034 SHALL cover: now near wrap, request at now=16'hFFF0 and response 0x20 cycles later -> lat=32, not a large value.
REQ-035 SHALL cover: 3 IDs outstanding, afu_rst asserted for 1 cycle -> all outputs at reset values; a later response to an old ID sets err_orphan.

Source files
------------

// File: rtl/afu_rd_lat_mon.sv
`default_nettype none
// ============================================================================
// Module      : afu_rd_lat_mon
// Description : Per-ID read latency monitor. Timestamps accepted read requests
//               in an ID-indexed table, measures the latency of each matching
//               response and keeps min/max/sum/count statistics plus sticky
//               duplicate-request and orphan-response flags.
// Revision    : 1.0 - initial release
// ============================================================================
module afu_rd_lat_mon #(
  parameter int ID_BITS = 8,
  parameter int TS_W    = 16
) (
  input  logic               afu_clk,
  input  logic               afu_rst,
  input  logic               req_fire,
  input  logic [ID_BITS-1:0] req_id,
  input  logic               rsp_fire,
  input  logic [ID_BITS-1:0] rsp_id,
  input  logic               stat_clr,
  output logic [TS_W-1:0]    lat_min,
  output logic [TS_W-1:0]    lat_max,
  output logic [47:0]        lat_sum,
  output logic [31:0]        rsp_cnt,
  output logic [ID_BITS:0]   outstanding,
  output logic               err_dup,
  output logic               err_orphan
);

  localparam int C_DEPTH = 1 << ID_BITS;

  logic [TS_W-1:0]    r_now;
  logic [C_DEPTH-1:0] r_vld;
  logic [TS_W-1:0]    r_ts [C_DEPTH];
  logic [TS_W-1:0]    r_lat_min;
  logic [TS_W-1:0]    r_lat_max;
  logic [47:0]        r_lat_sum;
  logic [31:0]        r_rsp_cnt;
  logic [ID_BITS:0]   r_outstanding;
  logic               r_err_dup;
  logic               r_err_orphan;

  logic               w_rsp_match;
  logic               w_rsp_orphan;
  logic               w_same_id;
  logic               w_req_dup;
  logic               w_req_new;
  logic [TS_W-1:0]    w_lat;
  logic [48:0]        w_sum_ext;
  logic [47:0]        w_sum_next;
  logic [31:0]        w_cnt_next;

  // Classify this cycle's request/response and precompute saturated updates.
  // A same-ID request and matched response retire the entry first, so the
  // request then counts as new (net outstanding change of zero, no dup).
  always_comb begin
    w_rsp_match  = rsp_fire && r_vld[rsp_id];
    w_rsp_orphan = rsp_fire && !r_vld[rsp_id];
    w_same_id    = req_fire && rsp_fire && (req_id == rsp_id);
    w_req_dup    = req_fire && r_vld[req_id] && !w_same_id;
    w_req_new    = req_fire && !w_req_dup;
    w_lat        = r_now - r_ts[rsp_id];
    w_sum_ext    = {1'b0, r_lat_sum} + {{(49-TS_W){1'b0}}, w_lat};
    w_sum_next   = w_sum_ext[48] ? {48{1'b1}} : w_sum_ext[47:0];
    w_cnt_next   = (&r_rsp_cnt) ? r_rsp_cnt : r_rsp_cnt + 32'd1;
  end

  // Free-running timestamp counter, wraps naturally.
  always_ff @(posedge afu_clk) begin
    if (afu_rst) r_now <= '0;
    else         r_now <= r_now + 1'b1;
  end

  // Timestamp table; contents are don't-care while the valid bit is clear.
  always_ff @(posedge afu_clk) begin
    if (!afu_rst && req_fire) r_ts[req_id] <= r_now;
  end

  // Valid bits: clear on a matched response, then (re)arm on a request.
  always_ff @(posedge afu_clk) begin
    if (afu_rst) begin
      r_vld <= '0;
    end else begin
      if (w_rsp_match) r_vld[rsp_id] <= 1'b0;
      if (req_fire)    r_vld[req_id] <= 1'b1;
    end
  end

  // Outstanding-entry count tracks the number of set valid bits.
  always_ff @(posedge afu_clk) begin
    if (afu_rst) begin
      r_outstanding <= '0;
    end else begin
      case ({w_req_new, w_rsp_match})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Statistics and sticky flags; a clear discards same-cycle events.
  always_ff @(posedge afu_clk) begin
    if (afu_rst || stat_clr) begin
      r_lat_min    <= '1;
      r_lat_max    <= '0;
      r_lat_sum    <= '0;
      r_rsp_cnt    <= '0;
      r_err_dup    <= 1'b0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_rsp_match) begin
        if (w_lat < r_lat_min) r_lat_min <= w_lat;
        if (w_lat > r_lat_max) r_lat_max <= w_lat;
        r_lat_sum <= w_sum_next;
        r_rsp_cnt <= w_cnt_next;
      end
      if (w_req_dup)    r_err_dup    <= 1'b1;
      if (w_rsp_orphan) r_err_orphan <= 1'b1;
    end
  end

  assign lat_min     = r_lat_min;
  assign lat_max     = r_lat_max;
  assign lat_sum     = r_lat_sum;
  assign rsp_cnt     = r_rsp_cnt;
  assign outstanding = r_outstanding;
  assign err_dup     = r_err_dup;
  assign err_orphan  = r_err_orphan;

endmodule
`default_nettype wire
